// File: rtl/firewall_pkg.sv
// Shared constants and types for the firewall ingress pipeline:
// Ethernet/IPv4 field values, the 5-tuple record and the parser state encoding.
package firewall_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    localparam int unsigned MIN_IPV4_LEN   = 34;
    localparam int unsigned BYTE_CNT_W     = 11;

    typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  protocol;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } five_tuple_t;

    typedef enum logic {
        PARSE = 1'b0,
        EMIT  = 1'b1
    } parser_state_e;

    // Byte offset of the L4 header inside the Ethernet frame.
    function automatic byte_cnt_t l4_offset(input logic [3:0] ihl);
        return byte_cnt_t'(14) + byte_cnt_t'({ihl, 2'b00});
    endfunction

endpackage

// File: rtl/header_parser.sv
// Extracts the IPv4 5-tuple from an Ethernet byte stream and hands it to the
// firewall stage; counts frames emitted and frames dropped.
module header_parser
    import firewall_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_axis_tdata,
    input  logic         rx_axis_tvalid,
    output logic         rx_axis_tready,
    input  logic         rx_axis_tlast,
    input  logic         rx_axis_tuser,
    output logic [103:0] m_axis_header_tdata,
    input  logic         m_axis_header_tready,
    output logic         m_axis_header_tvalid,
    output logic [15:0]  frames_ok,
    output logic [15:0]  frames_dropped
);

    parser_state_e state_q, state_d;

    byte_cnt_t   cnt_q, cnt_d;
    logic [15:0] ethertype_q, ethertype_d;
    logic [3:0]  version_q, version_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;

    five_tuple_t hdr_q, hdr_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    logic        beat;
    logic        frame_end;
    logic        frame_good;
    logic        is_l4;
    byte_cnt_t   l4_off_q;
    logic [11:0] frame_len;
    logic [11:0] min_len;

    assign beat      = rx_axis_tvalid && rx_axis_tready;
    assign frame_end = beat && rx_axis_tlast;
    assign l4_off_q  = l4_offset(ihl_q);

    // ---------------------------------------------------------------- capture
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        ethertype_d = ethertype_q;
        version_d   = version_q;
        ihl_d       = ihl_q;
        proto_d     = proto_q;
        src_ip_d    = src_ip_q;
        dst_ip_d    = dst_ip_q;
        src_port_d  = src_port_q;
        dst_port_d  = dst_port_q;

        if (beat) begin
            if (rx_axis_tlast)
                cnt_d = '0;
            else if (cnt_q != '1)
                cnt_d = cnt_q + byte_cnt_t'(1);

            case (cnt_q)
                byte_cnt_t'(12): ethertype_d[15:8] = rx_axis_tdata;
                byte_cnt_t'(13): ethertype_d[7:0]  = rx_axis_tdata;
                byte_cnt_t'(14): begin
                    version_d = rx_axis_tdata[7:4];
                    ihl_d     = rx_axis_tdata[3:0];
                end
                byte_cnt_t'(23): proto_d          = rx_axis_tdata;
                byte_cnt_t'(26): src_ip_d[31:24]  = rx_axis_tdata;
                byte_cnt_t'(27): src_ip_d[23:16]  = rx_axis_tdata;
                byte_cnt_t'(28): src_ip_d[15:8]   = rx_axis_tdata;
                byte_cnt_t'(29): src_ip_d[7:0]    = rx_axis_tdata;
                byte_cnt_t'(30): dst_ip_d[31:24]  = rx_axis_tdata;
                byte_cnt_t'(31): dst_ip_d[23:16]  = rx_axis_tdata;
                byte_cnt_t'(32): dst_ip_d[15:8]   = rx_axis_tdata;
                byte_cnt_t'(33): dst_ip_d[7:0]    = rx_axis_tdata;
                default: ;
            endcase

            // Port offsets are only meaningful once a legal IHL has been latched.
            if (ihl_q >= 4'd5) begin
                if (cnt_q == l4_off_q)                   src_port_d[15:8] = rx_axis_tdata;
                if (cnt_q == l4_off_q + byte_cnt_t'(1))  src_port_d[7:0]  = rx_axis_tdata;
                if (cnt_q == l4_off_q + byte_cnt_t'(2))  dst_port_d[15:8] = rx_axis_tdata;
                if (cnt_q == l4_off_q + byte_cnt_t'(3))  dst_port_d[7:0]  = rx_axis_tdata;
            end
        end
    end

    // ------------------------------------------------------------ frame check
    // Uses the _d view so a field byte arriving on the tlast beat still counts.
    always_comb begin
        is_l4      = (proto_d == PROTO_TCP) || (proto_d == PROTO_UDP);
        frame_len  = {1'b0, cnt_q} + 12'd1;
        min_len    = is_l4 ? ({1'b0, l4_offset(ihl_d)} + 12'd4) : 12'(MIN_IPV4_LEN);
        frame_good = (ethertype_d == ETHERTYPE_IPV4) && (version_d == 4'd4) &&
                     (ihl_d >= 4'd5) && (frame_len >= min_len) && !rx_axis_tuser;
    end

    always_comb begin
        hdr_d            = hdr_q;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;

        if (frame_end) begin
            if (frame_good) begin
                hdr_d.src_ip   = src_ip_d;
                hdr_d.dst_ip   = dst_ip_d;
                hdr_d.protocol = proto_d;
                hdr_d.src_port = is_l4 ? src_port_d : 16'h0000;
                hdr_d.dst_port = is_l4 ? dst_port_d : 16'h0000;
            end else begin
                frames_dropped_d = frames_dropped_q + 16'd1;
            end
        end

        if (state_q == EMIT && m_axis_header_tready)
            frames_ok_d = frames_ok_q + 16'd1;
    end

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) state_q <= PARSE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PARSE:   if (frame_end && frame_good) state_d = EMIT;
            EMIT:    if (m_axis_header_tready)    state_d = PARSE;
            default: state_d = PARSE;
        endcase
    end

    always_comb begin
        rx_axis_tready       = (state_q == PARSE) && !rst;
        m_axis_header_tvalid = (state_q == EMIT);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q            <= '0;
            ethertype_q      <= '0;
            version_q        <= '0;
            ihl_q            <= '0;
            proto_q          <= '0;
            src_ip_q         <= '0;
            dst_ip_q         <= '0;
            src_port_q       <= '0;
            dst_port_q       <= '0;
            hdr_q            <= '0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            cnt_q            <= cnt_d;
            hdr_q            <= hdr_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
            // Captured fields never leak from one frame into the next.
            if (frame_end) begin
                ethertype_q <= '0;
                version_q   <= '0;
                ihl_q       <= '0;
                proto_q     <= '0;
                src_ip_q    <= '0;
                dst_ip_q    <= '0;
                src_port_q  <= '0;
                dst_port_q  <= '0;
            end else begin
                ethertype_q <= ethertype_d;
                version_q   <= version_d;
                ihl_q       <= ihl_d;
                proto_q     <= proto_d;
                src_ip_q    <= src_ip_d;
                dst_ip_q    <= dst_ip_d;
                src_port_q  <= src_port_d;
                dst_port_q  <= dst_port_d;
            end
        end
    end

    assign m_axis_header_tdata = hdr_q;
    assign frames_ok           = frames_ok_q;
    assign frames_dropped      = frames_dropped_q;

endmodule

// File: tb/tb_header_parser.sv
// Directed bench for header_parser: hand-built Ethernet/IPv4 frames with
// hand-computed 5-tuples, drop cases, back-pressure and mid-frame reset.
module tb_header_parser;
    import firewall_pkg::*;

    localparam int FRM_MAX = 2200;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_axis_tdata;
    logic         rx_axis_tvalid;
    logic         rx_axis_tready;
    logic         rx_axis_tlast;
    logic         rx_axis_tuser;
    logic [103:0] m_axis_header_tdata;
    logic         m_axis_header_tvalid;
    logic         m_axis_header_tready;
    logic [15:0]  frames_ok;
    logic [15:0]  frames_dropped;

    always #5 clk = ~clk;

    header_parser dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_axis_tdata        (rx_axis_tdata),
        .rx_axis_tvalid       (rx_axis_tvalid),
        .rx_axis_tready       (rx_axis_tready),
        .rx_axis_tlast        (rx_axis_tlast),
        .rx_axis_tuser        (rx_axis_tuser),
        .m_axis_header_tdata  (m_axis_header_tdata),
        .m_axis_header_tready (m_axis_header_tready),
        .m_axis_header_tvalid (m_axis_header_tvalid),
        .frames_ok            (frames_ok),
        .frames_dropped       (frames_dropped)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int hs_base;

    logic [7:0] frm [0:FRM_MAX-1];

    // Counts real output handshakes at the clock edge they happen on.
    always @(posedge clk)
        if (!rst && m_axis_header_tvalid && m_axis_header_tready)
            hs_count <= hs_count + 1;

    task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_frame(input logic [15:0] etype, input logic [3:0] ihl,
                               input logic [7:0] proto, input logic [31:0] sip,
                               input logic [31:0] dip, input logic [15:0] sp,
                               input logic [15:0] dp);
        int l4;
        for (int i = 0; i < FRM_MAX; i++) frm[i] = 8'(i * 7 + 3);
        l4 = 14 + 4 * int'(ihl);
        frm[12] = etype[15:8];
        frm[13] = etype[7:0];
        frm[14] = {4'h4, ihl};
        frm[23] = proto;
        for (int k = 0; k < 4; k++) begin
            frm[26 + k] = 8'(sip >> (24 - 8 * k));
            frm[30 + k] = 8'(dip >> (24 - 8 * k));
        end
        for (int i = 34; i < l4; i++) frm[i] = 8'h99;
        frm[l4]     = sp[15:8];
        frm[l4 + 1] = sp[7:0];
        frm[l4 + 2] = dp[15:8];
        frm[l4 + 3] = dp[7:0];
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic user);
        int waited = 0;
        rx_axis_tdata  = b;
        rx_axis_tvalid = 1'b1;
        rx_axis_tlast  = last;
        rx_axis_tuser  = user;
        while (rx_axis_tready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("rx_tready_timeout", 104'(rx_axis_tready), 104'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int len, input logic user_last, input logic user_mid);
        for (int i = 0; i < len; i++)
            send_byte(frm[i], i == len - 1, (i == len - 1) ? user_last : user_mid);
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
    endtask

    task automatic expect_emit(input string tag, input logic [103:0] exp);
        check({tag, "_tvalid"},       104'(m_axis_header_tvalid), 104'd1);
        check({tag, "_tdata"},        m_axis_header_tdata,        exp);
        check({tag, "_rx_tready"},    104'(rx_axis_tready),       104'd0);
        @(negedge clk);
        check({tag, "_tvalid_1cyc"},  104'(m_axis_header_tvalid), 104'd0);
    endtask

    task automatic expect_drop(input string tag);
        check({tag, "_no_tvalid"}, 104'(m_axis_header_tvalid), 104'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        rx_axis_tdata        = '0;
        rx_axis_tvalid       = 1'b0;
        rx_axis_tlast        = 1'b0;
        rx_axis_tuser        = 1'b0;
        m_axis_header_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx_tready", 104'(rx_axis_tready), 104'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid",    104'(m_axis_header_tvalid), 104'd0);
        check("rst_tdata",     m_axis_header_tdata,        104'd0);
        check("rst_ok",        104'(frames_ok),            104'd0);
        check("rst_dropped",   104'(frames_dropped),       104'd0);
        check("rst_rx_ready1", 104'(rx_axis_tready),       104'd1);

        // 60-byte TCP, tuser toggled on non-last beats (must be ignored)
        build_frame(16'h0800, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050);
        send_frame(60, 1'b0, 1'b1);
        expect_emit("tcp60", 104'h0A000001_0A000002_06_1234_0050);
        check("tcp60_ok", 104'(frames_ok), 104'd1);

        // UDP with IHL=6: options at 34..37, ports at 38..41
        build_frame(16'h0800, 4'd6, 8'd17, 32'hC0A8010A, 32'hAC100005, 16'h0035, 16'hC000);
        send_frame(64, 1'b0, 1'b0);
        expect_emit("udp_ihl6", 104'hC0A8010A_AC100005_11_0035_C000);
        check("udp_ok", 104'(frames_ok), 104'd2);

        // ICMP, 42 bytes: ports forced to zero
        build_frame(16'h0800, 4'd5, 8'd1, 32'h01020304, 32'h05060708, 16'hBEEF, 16'hCAFE);
        send_frame(42, 1'b0, 1'b0);
        expect_emit("icmp42", 104'h01020304_05060708_01_0000_0000);
        check("icmp_ok", 104'(frames_ok), 104'd3);

        // Four drop cases
        build_frame(16'h86DD, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050);
        send_frame(60, 1'b0, 1'b0);
        expect_drop("drop_ipv6");
        build_frame(16'h0800, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050);
        send_frame(60, 1'b1, 1'b0);
        expect_drop("drop_tuser");
        send_frame(30, 1'b0, 1'b0);
        expect_drop("drop_runt30");
        send_frame(1, 1'b0, 1'b0);
        expect_drop("drop_1byte");
        check("drops_dropped", 104'(frames_dropped), 104'd4);
        check("drops_ok",      104'(frames_ok),      104'd3);
        check("drops_hs",      104'(hs_count),       104'd3);

        // Length boundary for TCP IHL=5: 38 bytes is the minimum, 37 is a runt
        send_frame(38, 1'b0, 1'b0);
        expect_emit("tcp38", 104'h0A000001_0A000002_06_1234_0050);
        send_frame(37, 1'b0, 1'b0);
        expect_drop("drop_tcp37");
        check("bound_ok",      104'(frames_ok),      104'd4);
        check("bound_dropped", 104'(frames_dropped), 104'd5);

        // Back-pressure: 10 stalled cycles, next frame's byte 0 waiting on the bus
        m_axis_header_tready = 1'b0;
        build_frame(16'h0800, 4'd5, 8'd17, 32'h7F000001, 32'h7F000002, 16'h1388, 16'h1389);
        send_frame(50, 1'b0, 1'b0);
        build_frame(16'h0800, 4'd5, 8'd6, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h0016, 16'hFFFF);
        rx_axis_tdata  = frm[0];
        rx_axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("stall_tvalid",    104'(m_axis_header_tvalid), 104'd1);
            check("stall_tdata",     m_axis_header_tdata, 104'h7F000001_7F000002_11_1388_1389);
            check("stall_rx_tready", 104'(rx_axis_tready), 104'd0);
            @(negedge clk);
        end
        check("stall_ok_held", 104'(frames_ok), 104'd4);
        m_axis_header_tready = 1'b1;
        @(negedge clk);
        check("stall_rel_tvalid",   104'(m_axis_header_tvalid), 104'd0);
        check("stall_rel_ok",       104'(frames_ok),            104'd5);
        check("stall_rel_rx_ready", 104'(rx_axis_tready),       104'd1);
        send_frame(60, 1'b0, 1'b0);
        expect_emit("after_stall", 104'h0A0A0A0A_0B0B0B0B_06_0016_FFFF);
        check("after_stall_ok", 104'(frames_ok), 104'd6);

        // Frame longer than the saturating byte counter
        build_frame(16'h0800, 4'd5, 8'd6, 32'hC0000201, 32'hC6336401, 16'h01BB, 16'hD431);
        send_frame(2100, 1'b0, 1'b0);
        expect_emit("long2100", 104'hC0000201_C6336401_06_01BB_D431);
        check("long_ok", 104'(frames_ok), 104'd7);

        // Reset at byte 20, then a good frame
        build_frame(16'h0800, 4'd5, 8'd6, 32'h11111111, 32'h22222222, 16'h4444, 16'h5555);
        for (int i = 0; i < 20; i++) send_byte(frm[i], 1'b0, 1'b0);
        rx_axis_tvalid = 1'b0;
        rst = 1'b1;
        hs_base = hs_count;
        @(negedge clk);
        check("midrst_rx_tready", 104'(rx_axis_tready),       104'd0);
        check("midrst_ok",        104'(frames_ok),            104'd0);
        check("midrst_dropped",   104'(frames_dropped),       104'd0);
        check("midrst_tdata",     m_axis_header_tdata,        104'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tvalid",    104'(m_axis_header_tvalid), 104'd0);
        build_frame(16'h0800, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050);
        send_frame(60, 1'b0, 1'b0);
        expect_emit("post_rst", 104'h0A000001_0A000002_06_1234_0050);
        check("post_rst_ok",      104'(frames_ok),            104'd1);
        check("post_rst_dropped", 104'(frames_dropped),       104'd0);
        check("post_rst_hs",      104'(hs_count - hs_base),   104'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/header_parser.md
HEADER_PARSER -- requirements
Module: header_parser

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports rx_axis_tdata/tvalid/tready/tlast/tuser, 8/1/1/1/1, Ethernet byte stream in; tuser=1 on the tlast beat marks a bad frame.
REQ-004 SHALL have ports m_axis_header_tdata/tvalid/tready, out/out/in, 104/1/1, 5-tuple to the firewall stage; packing {src_ip[103:72], dst_ip[71:40], protocol[39:32], src_port[31:16], dst_port[15:0]}.
REQ-005 SHALL have ports frames_ok and frames_dropped, output, 16 each, wrapping statistics counters.

Function
REQ-006 SHALL implement the FSM PARSE -> EMIT -> PARSE; reset state is PARSE.
REQ-007 SHALL drive rx_axis_tready=1 in PARSE and 0 in EMIT; a beat is accepted only when tvalid&&tready.
REQ-008 SHALL count accepted bytes per frame with an 11-bit counter, cleared after tlast, saturating at 2047.
REQ-009 SHALL treat byte 0 as the first byte after tlast or reset, with no preamble or SFD.
REQ-010 SHALL capture ethertype from bytes 12-13; only 0x0800 is parsed.
REQ-011 SHALL require byte 14 high nibble = 4; IHL is the low nibble, and IHL<5 marks the frame invalid.
REQ-012 SHALL capture protocol from byte 23, src_ip from bytes 26-29 and dst_ip from bytes 30-33, big-endian.
REQ-013 SHALL define L4 offset = 14 + 4*IHL; for protocol 6 or 17, src_port is bytes L4..L4+1 and dst_port is bytes L4+2..L4+3, big-endian.
REQ-014 SHALL emit src_port=0 and dst_port=0 for any other protocol.
REQ-015 SHALL set the minimum valid length to 34 bytes, or L4+4 bytes for TCP/UDP; shorter frames are runts.
REQ-016 SHALL, on the accepted tlast beat of a frame that is good (IPv4, valid version/IHL, not runt, tuser=0), load the output register and enter EMIT on the next cycle.
REQ-017 SHALL, on the tlast beat of any other frame, stay in PARSE, discard captured fields and increment frames_dropped.
REQ-018 SHALL hold m_axis_header_tvalid=1 and keep tdata stable in EMIT until tready.
REQ-019 SHALL, on the EMIT cycle where tready=1, increment frames_ok and return to PARSE in the next cycle.
REQ-020 SHALL meet latency: tvalid rises 1 cycle after the good tlast beat; with tready tied high, tvalid lasts 1 cycle; minimum frame-to-frame gap is 1 dead rx cycle.
REQ-021 SHALL treat a 1-byte frame (tlast on byte 0) as a runt drop.
REQ-022 SHALL treat frames longer than 2047 bytes as still valid, relying on the counter saturating only after all header bytes are captured.
REQ-023 SHALL ignore tuser on non-tlast beats.
REQ-024 SHALL allow both counters to wrap 0xFFFF -> 0x0000.

Reset
REQ-025 SHALL on rst=1 at a clock edge set: state=PARSE, byte counter=0, captured fields=0, m_axis_header_tdata=0, m_axis_header_tvalid=0, rx_axis_tready=0 during the reset cycle, frames_ok=0, frames_dropped=0.
REQ-026 SHALL, on reset asserted mid-frame or in EMIT, discard the pending header without emitting it; the next accepted byte after release is byte 0.

Structure
REQ-027 SHALL place ETHERTYPE_IPV4=16'h0800, PROTO_TCP=8'd6, PROTO_UDP=8'd17, MIN_IPV4_LEN=34, and a packed struct typedef for the 104-bit 5-tuple in shared package firewall_pkg.
REQ-028 SHALL be implemented as a single flat module with no sub-module: byte-offset capture logic, FSM, output register and counters.

Verification
REQ-029 SHALL cover: 60-byte TCP frame, IHL=5, 10.0.0.1 -> 10.0.0.2, ports 0x1234 -> 0x0050 -> one header 0x0A000001_0A000002_06_1234_0050 one cycle after tlast; frames_ok=1.
REQ-030 SHALL cover: UDP frame with IHL=6 and ports at bytes 38-41 (0x0035, 0xC000) -> header ports 0035/C000, with option bytes ignored.
REQ-031 SHALL cover: ICMP frame (protocol 1) of 42 bytes -> ports=0000/0000, protocol=01.
REQ-032 SHALL cover four drop cases, each giving no header and frames_dropped=4 after all four:
  - ethertype 0x86DD;
  - tuser=1 on tlast;
  - a 30-byte frame;
  - a 1-byte frame.
REQ-033 SHALL cover: m_axis_header_tready held low 10 cycles -> tvalid held, tdata stable, rx_axis_tready=0 throughout; a following frame starts only after the handshake.
REQ-034 SHALL cover: rst pulsed at byte 20 of a frame, then a good frame is sent -> only the second frame's header is emitted, and both counters read 0 then frames_ok=1.
